// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder: mnemonic codes,
// opcode values and the bit positions of each instruction field.
package instr_encoder_pkg;

  // Mnemonic codes on mnem_i; codes 13..15 are illegal.
  typedef enum logic [3:0] {
    MN_RTYPE = 4'd0,
    MN_ADDI  = 4'd1,
    MN_SLTIU = 4'd2,
    MN_BEQ   = 4'd3,
    MN_LUI   = 4'd4,
    MN_ORI   = 4'd5,
    MN_BNE   = 4'd6,
    MN_LW    = 4'd7,
    MN_SW    = 4'd8,
    MN_BLEZ  = 4'd9,
    MN_BGTZ  = 4'd10,
    MN_J     = 4'd11,
    MN_JAL   = 4'd12
  } mnem_e;

  // Primary opcode values.
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BLEZ  = 6'd6;
  localparam logic [5:0] OP_BGTZ  = 6'd7;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;

  // Least-significant bit position of each field in the 32-bit word.
  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;

  // Field formats.
  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_J = 2'd2
  } fmt_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: selects opcode and format for a mnemonic,
// applies the forced-zero register fields, and flags illegal mnemonics.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  mnem_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] instr_o,
  output logic        legal_o
);

  logic [5:0] w_op;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  fmt_e       w_fmt;

  // Decode mnemonic into opcode, format and effective rs/rt.
  always_comb begin
    w_op    = OP_RTYPE;
    w_fmt   = FMT_I;
    w_rs    = rs_i;
    w_rt    = rt_i;
    legal_o = 1'b1;
    case (mnem_i)
      MN_RTYPE: begin w_op = OP_RTYPE; w_fmt = FMT_R; end
      MN_ADDI:  w_op = OP_ADDI;
      MN_SLTIU: w_op = OP_SLTIU;
      MN_BEQ:   w_op = OP_BEQ;
      MN_LUI:   begin w_op = OP_LUI; w_rs = 5'd0; end
      MN_ORI:   w_op = OP_ORI;
      MN_BNE:   w_op = OP_BNE;
      MN_LW:    w_op = OP_LW;
      MN_SW:    w_op = OP_SW;
      MN_BLEZ:  begin w_op = OP_BLEZ; w_rt = 5'd0; end
      MN_BGTZ:  begin w_op = OP_BGTZ; w_rt = 5'd0; end
      MN_J:     begin w_op = OP_J;   w_fmt = FMT_J; end
      MN_JAL:   begin w_op = OP_JAL; w_fmt = FMT_J; end
      default:  legal_o = 1'b0;
    endcase
  end

  // Assemble the word from the fields according to the format.
  always_comb begin
    instr_o = 32'(w_op) << OP_LSB;
    case (w_fmt)
      FMT_R: instr_o = instr_o | (32'(w_rs) << RS_LSB) | (32'(w_rt) << RT_LSB)
                     | (32'(rd_i) << RD_LSB) | (32'(shamt_i) << SHAMT_LSB)
                     | 32'(funct_i);
      FMT_J: instr_o = instr_o | 32'(target_i);
      default: instr_o = instr_o | (32'(w_rs) << RS_LSB) | (32'(w_rt) << RT_LSB)
                       | 32'(imm_i);
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: packs fields into a word, buffers it with its
// byte address in a 2-entry FIFO, and counts accepted words.
// Optional feature macro: ENC_ILLEGAL_CHECK_EN (drop illegal mnemonics and
// raise a sticky err_o instead of emitting a zero word).
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  mnem_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] addr_o,
  output logic [15:0] count_o,
  output logic        err_o
);

  logic [31:0] r_word [2];
  logic [31:0] r_waddr [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_fill;
  logic [31:0] r_addr_cnt;
  logic [15:0] r_count;

  logic [31:0] w_packed;
  logic [31:0] w_word;
  logic        w_legal;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  instr_pack u_pack (
    .mnem_i   (mnem_i),
    .rs_i     (rs_i),
    .rt_i     (rt_i),
    .rd_i     (rd_i),
    .shamt_i  (shamt_i),
    .funct_i  (funct_i),
    .imm_i    (imm_i),
    .target_i (target_i),
    .instr_o  (w_packed),
    .legal_o  (w_legal)
  );

  // Illegal mnemonics never reach the FIFO as anything but an all-zero word.
  assign w_word      = w_legal ? w_packed : 32'd0;
  // Gating with rst_i keeps ready low for the whole asynchronous reset.
  assign in_ready_o  = rst_i && (r_fill != 2'd2) && !start_i;
  assign w_accept    = in_valid_i && in_ready_o;
`ifdef ENC_ILLEGAL_CHECK_EN
  assign w_push      = w_accept && w_legal;
`else
  assign w_push      = w_accept;
`endif
  assign out_valid_o = (r_fill != 2'd0);
  assign w_pop       = out_valid_o && out_ready_i;
  assign instr_o     = r_word[r_rd_ptr];
  assign addr_o      = r_waddr[r_rd_ptr];
  assign count_o     = r_count;

  // FIFO storage, pointers and occupancy; start flushes without clearing data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_word[0]  <= 32'd0;
      r_word[1]  <= 32'd0;
      r_waddr[0] <= 32'd0;
      r_waddr[1] <= 32'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_fill     <= 2'd0;
    end else if (start_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_fill   <= 2'd0;
    end else begin
      if (w_push) begin
        r_word[r_wr_ptr]  <= w_word;
        r_waddr[r_wr_ptr] <= r_addr_cnt;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_push && !w_pop) begin
        r_fill <= r_fill + 2'd1;
      end else if (w_pop && !w_push) begin
        r_fill <= r_fill - 2'd1;
      end
    end
  end

  // Address counter (wraps naturally) and saturating word count.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_addr_cnt <= 32'd0;
      r_count    <= 16'd0;
    end else if (start_i) begin
      r_addr_cnt <= base_addr_i;
      r_count    <= 16'd0;
    end else if (w_push) begin
      r_addr_cnt <= r_addr_cnt + 32'd4;
      if (r_count != 16'hFFFF) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

`ifdef ENC_ILLEGAL_CHECK_EN
  logic r_err;

  // Sticky flag for an accepted illegal mnemonic, cleared by start.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_err <= 1'b0;
    end else if (start_i) begin
      r_err <= 1'b0;
    end else if (w_accept && !w_legal) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk_i  in  1  single clock; all state updates on rising edge.
REQ-002 rst_i  in  1  asynchronous, active-low reset.
REQ-003 start_i  in  1  begin a new program: flush buffer, load base_addr_i, clear count.
REQ-004 base_addr_i  in  32  byte address of the first emitted word.
REQ-005 in_valid_i / in_ready_o  in/out  1/1  field-input handshake; transfer when both are high.
REQ-006 mnem_i  in  4  mnemonic code: RTYPE, ADDI, SLTIU, BEQ, LUI, ORI, BNE, LW, SW, BLEZ, BGTZ, J, JAL; other codes illegal.
REQ-007 rs_i, rt_i, rd_i, shamt_i  in  5 each  register and shift fields.
REQ-008 funct_i  in  6; imm_i  in  16; target_i  in  26  function, immediate and jump-target fields.
REQ-009 out_valid_o / out_ready_i  out/in  1/1  encoded-word handshake.
REQ-010 instr_o  out  32  encoded MIPS instruction word.
REQ-011 addr_o  out  32  byte address paired with instr_o.
REQ-012 count_o  out  16  number of words accepted since the last start or reset.
REQ-013 err_o  out  1  sticky illegal-mnemonic flag.

Function
REQ-014 Opcodes SHALL be: RTYPE 0, ADDI 8, SLTIU 11, BEQ 4, LUI 15, ORI 13, BNE 5, LW 35, SW 43, BLEZ 6, BGTZ 7, J 2, JAL 3.
REQ-015 R-type SHALL pack op|rs|rt|rd|shamt|funct; I-type op|rs|rt|imm; J-type op|target.
REQ-016 LUI SHALL force rs=0; BLEZ and BGTZ SHALL force rt=0.
REQ-017 The encoded word SHALL go into a 2-entry FIFO; in_ready_o = (entries < 2) and not start_i.
REQ-018 Latency: a word accepted in cycle N SHALL be valid on instr_o no earlier than N+1.
REQ-019 Each entry SHALL carry its own address; the address counter SHALL advance by 4 per accepted word and wrap modulo 2^32.
REQ-020 Push and pop in the same cycle SHALL leave the occupancy unchanged and preserve order.
REQ-021 out_valid_o SHALL stay high and instr_o/addr_o stable until out_ready_i is high.
REQ-022 start_i SHALL take priority over a simultaneous input: the input is not accepted, the FIFO empties, the address counter loads base_addr_i, count_o clears, err_o clears.
REQ-023 count_o SHALL saturate at 0xFFFF.

Reset
REQ-024 While rst_i is low: FIFO empty, out_valid_o=0, instr_o=0, addr_o=0, address counter=0, count_o=0, err_o=0, in_ready_o=0.
REQ-025 Reset asserted mid-transfer SHALL discard all buffered words; nothing is emitted after release until new input is accepted.

Configuration
REQ-026 With ENC_ILLEGAL_CHECK_EN defined: an illegal mnemonic SHALL be accepted and dropped, with no push, no address increment and no count change, and SHALL set err_o.
REQ-027 Without it: an illegal mnemonic SHALL encode as 0x00000000, be counted and advance the address; err_o SHALL be tied to 0.

Structure
REQ-028 A shared package SHALL hold the mnemonic enum, the opcode constants and the field-position constants.
REQ-029 A combinational sub-module instr_pack SHALL perform the field packing; instr_encoder owns the FIFO, counters and handshakes.

Verification
REQ-030 ADDI rs=0 rt=8 imm=5, base 0x00000000 -> instr_o=0x20080005, addr_o=0x00000000.
REQ-031 LW rs=29 rt=9 imm=4, then RTYPE rs=1 rt=2 rd=3 funct=0x20 -> 0x8FA90004 @0x0, then 0x00221820 @0x4.
REQ-032 J target=0x0000010, base 0xFFFFFFFC, two words -> 0x08000010 @0xFFFFFFFC, then the second word @0x00000000.
REQ-033 out_ready_i=0 and 3 inputs offered -> 2 accepted, in_ready_o=0; release out_ready_i -> 3 words in order, count_o=3.
REQ-034 mnem_i=0xF -> with the macro: err_o=1, count_o unchanged, no output; without it: instr_o=0x00000000.
REQ-035 start_i with 2 words buffered and in_valid_i high -> FIFO empty, the input is not accepted, addr reloads, count_o=0.
